// File: rtl/sat_bin_pkg.sv
// Shared bin-transfer definitions: FSM encodings, default bin geometry, base-address helper.
// Combinational only (no latency); no backpressure.
package sat_bin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bin_state_t;

    localparam int DEF_NUM_CLAUSES_A_BIN = 8;
    localparam int DEF_NUM_VARS_A_BIN    = 8;
    localparam int DEF_NUM_LVLS_A_BIN    = 8;
    localparam int DEF_WIDTH_VAR         = 12;
    localparam int DEF_WIDTH_LVL         = 16;
    localparam int DEF_WIDTH_BIN_ID      = 10;
    localparam int DEF_WIDTH_STATES      = 30;
    localparam int DEF_ADDR_WIDTH        = 9;
    localparam int CNT_W                 = 6;

    // Bins are 1-based and RAM slot 0 is reserved, hence the +1.
    function automatic logic [31:0] bin_base_addr(input logic [31:0] bin, input logic [31:0] n);
        return (bin - 32'd1) * n + 32'd1;
    endfunction

endpackage

// File: rtl/load_bin_vs_fetch.sv
// Two-hop var fetch: var id -> var-state RAM address -> one-hot strobe; 4 cycles from in_vld.
// Free-running pipeline, no backpressure; zero ids skip the RAM read and deliver a zero state.
module load_bin_vs_fetch
    import sat_bin_pkg::*;
#(
    parameter int NUM_VARS_A_BIN        = DEF_NUM_VARS_A_BIN,
    parameter int WIDTH_VAR             = DEF_WIDTH_VAR,
    parameter int WIDTH_VAR_STATES      = DEF_WIDTH_STATES,
    parameter int ADDR_WIDTH_VAR_STATES = DEF_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_vld,
    input  logic [CNT_W-1:0]                 in_idx,
    input  logic [WIDTH_VAR-1:0]             ram_data_v_i,
    output logic [ADDR_WIDTH_VAR_STATES-1:0] ram_addr_vs_o,
    input  logic [WIDTH_VAR_STATES-1:0]      ram_data_vs_i,
    output logic [NUM_VARS_A_BIN-1:0]        wr_var_states_o,
    output logic [WIDTH_VAR_STATES-1:0]      var_state_o,
    output logic                             busy
);

    localparam logic [NUM_VARS_A_BIN-1:0] V_ONE = NUM_VARS_A_BIN'(1);

    logic             vld_a, vld_b, vld_c;
    logic             zero_b, zero_c;
    logic [CNT_W-1:0] idx_a, idx_b, idx_c;
    logic             id_nz;

    assign id_nz = (ram_data_v_i != '0);
    assign busy  = vld_a | vld_b | vld_c | (|wr_var_states_o);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_a           <= 1'b0;
            vld_b           <= 1'b0;
            vld_c           <= 1'b0;
            zero_b          <= 1'b0;
            zero_c          <= 1'b0;
            idx_a           <= '0;
            idx_b           <= '0;
            idx_c           <= '0;
            ram_addr_vs_o   <= '0;
            wr_var_states_o <= '0;
            var_state_o     <= '0;
        end else begin
            vld_a <= in_vld;
            idx_a <= in_idx;

            // Var id is on ram_data_v_i while vld_a is high.
            if (vld_a) begin
                ram_addr_vs_o <= id_nz ? ram_data_v_i[ADDR_WIDTH_VAR_STATES-1:0] : '0;
                zero_b        <= ~id_nz;
            end else begin
                ram_addr_vs_o <= '0;
                zero_b        <= 1'b0;
            end
            vld_b <= vld_a;
            idx_b <= idx_a;

            vld_c  <= vld_b;
            zero_c <= zero_b;
            idx_c  <= idx_b;

            if (vld_c) begin
                wr_var_states_o <= V_ONE << idx_c;
                var_state_o     <= zero_c ? '0 : ram_data_vs_i;
            end else begin
                wr_var_states_o <= '0;
                var_state_o     <= '0;
            end
        end
    end

endmodule

// File: rtl/load_bin.sv
// Bin loader: streams one bin's clauses, var states and level states from BRAM into the SAT engine.
// Strobes 3 cycles (vars 5) after each address; no backpressure. Optional LOAD_BIN_LEARNT_MASK_EN.
module load_bin
    import sat_bin_pkg::*;
#(
    parameter int NUM_CLAUSES_A_BIN     = DEF_NUM_CLAUSES_A_BIN,
    parameter int NUM_VARS_A_BIN        = DEF_NUM_VARS_A_BIN,
    parameter int NUM_LVLS_A_BIN        = DEF_NUM_LVLS_A_BIN,
    parameter int WIDTH_CLAUSES         = NUM_VARS_A_BIN * 2,
    parameter int WIDTH_VAR             = DEF_WIDTH_VAR,
    parameter int WIDTH_LVL             = DEF_WIDTH_LVL,
    parameter int WIDTH_BIN_ID          = DEF_WIDTH_BIN_ID,
    parameter int WIDTH_VAR_STATES      = DEF_WIDTH_STATES,
    parameter int WIDTH_LVL_STATES      = DEF_WIDTH_STATES,
    parameter int ADDR_WIDTH_CLAUSES    = DEF_ADDR_WIDTH,
    parameter int ADDR_WIDTH_VAR        = DEF_ADDR_WIDTH,
    parameter int ADDR_WIDTH_VAR_STATES = DEF_ADDR_WIDTH,
    parameter int ADDR_WIDTH_LVL_STATES = DEF_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_load,
    input  logic [WIDTH_BIN_ID-1:0]          load_bin_num_i,
    input  logic [WIDTH_LVL-1:0]             base_lvl_i,
`ifdef LOAD_BIN_LEARNT_MASK_EN
    input  logic                             load_learnt_i,
`endif
    output logic                             apply_load_o,
    output logic                             done_load,
    output logic [ADDR_WIDTH_CLAUSES-1:0]    ram_addr_c_o,
    input  logic [WIDTH_CLAUSES-1:0]         ram_data_c_i,
    output logic [ADDR_WIDTH_VAR-1:0]        ram_addr_v_o,
    input  logic [WIDTH_VAR-1:0]             ram_data_v_i,
    output logic [ADDR_WIDTH_VAR_STATES-1:0] ram_addr_vs_o,
    input  logic [WIDTH_VAR_STATES-1:0]      ram_data_vs_i,
    output logic [ADDR_WIDTH_LVL_STATES-1:0] ram_addr_ls_o,
    input  logic [WIDTH_LVL_STATES-1:0]      ram_data_ls_i,
    output logic [NUM_CLAUSES_A_BIN-1:0]     wr_carray_o,
    output logic [WIDTH_CLAUSES-1:0]         clause_o,
    output logic [NUM_VARS_A_BIN-1:0]        wr_var_states_o,
    output logic [WIDTH_VAR_STATES-1:0]      var_state_o,
    output logic [NUM_LVLS_A_BIN-1:0]        wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES-1:0]      lvl_state_o
);

    localparam logic [CNT_W-1:0] NC_CNT  = CNT_W'(NUM_CLAUSES_A_BIN);
    localparam logic [CNT_W-1:0] NV_CNT  = CNT_W'(NUM_VARS_A_BIN);
    localparam logic [CNT_W-1:0] NL_CNT  = CNT_W'(NUM_LVLS_A_BIN);
    localparam logic [NUM_CLAUSES_A_BIN-1:0] C_ONE = NUM_CLAUSES_A_BIN'(1);
    localparam logic [NUM_LVLS_A_BIN-1:0]    L_ONE = NUM_LVLS_A_BIN'(1);

    bin_state_t                       state;
    logic [ADDR_WIDTH_CLAUSES-1:0]    cbase_q;
    logic [ADDR_WIDTH_VAR-1:0]        vbase_q;
    logic [ADDR_WIDTH_LVL_STATES-1:0] lbase_q;
    logic [CNT_W-1:0]                 cnt_c, cnt_v, cnt_l;
    logic                             c_vld0, c_vld1, l_vld0, l_vld1, v_vld0;
    logic [CNT_W-1:0]                 c_idx0, c_idx1, l_idx0, l_idx1, v_idx0;
    logic                             vs_busy, pipe_busy, cnt_done;
    logic                             c_go, v_go, l_go;
    logic [31:0]                      cbase_full, vbase_full;
    logic [WIDTH_LVL-1:0]             lbase_full;
    logic [WIDTH_CLAUSES-1:0]         clause_in;
    logic                             unused_ok;

    assign cbase_full = bin_base_addr(32'(load_bin_num_i), 32'(NUM_CLAUSES_A_BIN));
    assign vbase_full = bin_base_addr(32'(load_bin_num_i), 32'(NUM_VARS_A_BIN));
    assign lbase_full = base_lvl_i + WIDTH_LVL'(1);
    assign unused_ok  = ^{cbase_full, vbase_full, lbase_full};

    assign c_go      = (state == ST_ISSUE) && (cnt_c < NC_CNT);
    assign v_go      = (state == ST_ISSUE) && (cnt_v < NV_CNT);
    assign l_go      = (state == ST_ISSUE) && (cnt_l < NL_CNT);
    assign cnt_done  = (cnt_c == NC_CNT) && (cnt_v == NV_CNT) && (cnt_l == NL_CNT);
    // The output strobe registers count as in flight so DONE follows the last write.
    assign pipe_busy = c_vld0 | c_vld1 | (|wr_carray_o) |
                       l_vld0 | l_vld1 | (|wr_lvl_states_o) |
                       v_vld0 | vs_busy;

`ifdef LOAD_BIN_LEARNT_MASK_EN
    localparam logic [CNT_W-1:0] NC_HALF = CNT_W'(NUM_CLAUSES_A_BIN / 2);
    logic learnt_q;

    always_comb begin
        clause_in = ram_data_c_i;
        if (!learnt_q && (c_idx1 >= NC_HALF))
            clause_in = '0;
    end
`else
    always_comb begin
        clause_in = ram_data_c_i;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cbase_q      <= '0;
            vbase_q      <= '0;
            lbase_q      <= '0;
            cnt_c        <= '0;
            cnt_v        <= '0;
            cnt_l        <= '0;
            apply_load_o <= 1'b0;
            done_load    <= 1'b0;
`ifdef LOAD_BIN_LEARNT_MASK_EN
            learnt_q     <= 1'b0;
`endif
        end else begin
            apply_load_o <= (state != ST_IDLE);
            done_load    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_load) begin
                        state   <= ST_ISSUE;
                        cbase_q <= cbase_full[ADDR_WIDTH_CLAUSES-1:0];
                        vbase_q <= vbase_full[ADDR_WIDTH_VAR-1:0];
                        lbase_q <= lbase_full[ADDR_WIDTH_LVL_STATES-1:0];
                        cnt_c   <= '0;
                        cnt_v   <= '0;
                        cnt_l   <= '0;
`ifdef LOAD_BIN_LEARNT_MASK_EN
                        learnt_q <= load_learnt_i;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (c_go) cnt_c <= cnt_c + CNT_W'(1);
                    if (v_go) cnt_v <= cnt_v + CNT_W'(1);
                    if (l_go) cnt_l <= cnt_l + CNT_W'(1);
                    if (cnt_done) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!pipe_busy) begin
                        state     <= ST_DONE;
                        done_load <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Clause and level streams: address -> RAM data -> registered strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr_c_o    <= '0;
            ram_addr_ls_o   <= '0;
            ram_addr_v_o    <= '0;
            c_vld0          <= 1'b0;
            c_vld1          <= 1'b0;
            l_vld0          <= 1'b0;
            l_vld1          <= 1'b0;
            v_vld0          <= 1'b0;
            c_idx0          <= '0;
            c_idx1          <= '0;
            l_idx0          <= '0;
            l_idx1          <= '0;
            v_idx0          <= '0;
            wr_carray_o     <= '0;
            clause_o        <= '0;
            wr_lvl_states_o <= '0;
            lvl_state_o     <= '0;
        end else begin
            ram_addr_c_o  <= c_go ? cbase_q + ADDR_WIDTH_CLAUSES'(cnt_c) : '0;
            ram_addr_ls_o <= l_go ? lbase_q + ADDR_WIDTH_LVL_STATES'(cnt_l) : '0;
            ram_addr_v_o  <= v_go ? vbase_q + ADDR_WIDTH_VAR'(cnt_v) : '0;
            c_vld0 <= c_go;
            l_vld0 <= l_go;
            v_vld0 <= v_go;
            c_idx0 <= c_go ? cnt_c : '0;
            l_idx0 <= l_go ? cnt_l : '0;
            v_idx0 <= v_go ? cnt_v : '0;

            c_vld1 <= c_vld0;
            c_idx1 <= c_idx0;
            l_vld1 <= l_vld0;
            l_idx1 <= l_idx0;

            if (c_vld1) begin
                wr_carray_o <= C_ONE << c_idx1;
                clause_o    <= clause_in;
            end else begin
                wr_carray_o <= '0;
                clause_o    <= '0;
            end

            if (l_vld1) begin
                wr_lvl_states_o <= L_ONE << l_idx1;
                lvl_state_o     <= ram_data_ls_i;
            end else begin
                wr_lvl_states_o <= '0;
                lvl_state_o     <= '0;
            end
        end
    end

    load_bin_vs_fetch #(
        .NUM_VARS_A_BIN        (NUM_VARS_A_BIN),
        .WIDTH_VAR             (WIDTH_VAR),
        .WIDTH_VAR_STATES      (WIDTH_VAR_STATES),
        .ADDR_WIDTH_VAR_STATES (ADDR_WIDTH_VAR_STATES)
    ) u_vs_fetch (
        .clk             (clk),
        .rst             (rst),
        .in_vld          (v_vld0),
        .in_idx          (v_idx0),
        .ram_data_v_i    (ram_data_v_i),
        .ram_addr_vs_o   (ram_addr_vs_o),
        .ram_data_vs_i   (ram_data_vs_i),
        .wr_var_states_o (wr_var_states_o),
        .var_state_o     (var_state_o),
        .busy            (vs_busy)
    );

endmodule
